// File: rtl/audio_tone_if.sv
// rtl/audio_tone_if.sv - command and speaker signal bundle for the tone player
//
// Purpose: groups the held audio command word, the mute control and the
// speaker/status outputs so the player and its driver share one port.
//
// Signals:
//   audio_cmd  [15:0]  held command word: [15:12] duration D, [11:0] half-period P
//   mute               forces the speaker low without touching timing
//   speaker            square-wave output
//   busy               high while a note or rest is in progress
//   note_done          one-cycle pulse when a timed note ends naturally
//
// Modports:
//   master  drives audio_cmd/mute, observes the outputs (CPU / memory side)
//   slave   the tone player itself

interface audio_tone_if;
    logic [15:0] audio_cmd;
    logic        mute;
    logic        speaker;
    logic        busy;
    logic        note_done;

    modport master (
        output audio_cmd,
        output mute,
        input  speaker,
        input  busy,
        input  note_done
    );

    modport slave (
        input  audio_cmd,
        input  mute,
        output speaker,
        output busy,
        output note_done
    );
endinterface

// File: rtl/audio_tone_player.sv
// rtl/audio_tone_player.sv - square-wave tone generator driven by a held command word
//
// Purpose: watches the memory-mapped audio command register, starts a new
// note whenever the word changes, and drives a 1-bit speaker line. Notes are
// timed (D = 1..15 ticks) or sustained (D = 0); P = 0 is a rest.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    audio_tone_if.slave: audio_cmd, mute in; speaker, busy, note_done out
//
// Parameters:
//   PITCH_UNIT   clock cycles per pitch unit
//   TICK_CYCLES  clock cycles per duration tick

module audio_tone_player #(
    parameter int PITCH_UNIT  = 50,
    parameter int TICK_CYCLES = 3125000
) (
    input  logic        clk,
    input  logic        reset,
    audio_tone_if.slave bus
);

    localparam int PW = (PITCH_UNIT  > 1) ? $clog2(PITCH_UNIT)  : 1;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PITCH_UNIT - 1);
    localparam logic [TW-1:0] TK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        SUSTAIN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    // cmd_prev doubles as the latched D/P fields of the note in progress
    logic [15:0]   cmd_prev;
    logic [PW-1:0] prescale;
    logic [11:0]   half_cnt;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    tick_count;
    logic          tone;

    logic          change;
    logic          timed_end;
    logic [3:0]    d_cur;
    logic [11:0]   p_cur;

    assign d_cur  = cmd_prev[15:12];
    assign p_cur  = cmd_prev[11:0];
    assign change = (bus.audio_cmd != cmd_prev);

    // Last busy cycle of a timed note. A coinciding change wins, so the
    // natural end (and its note_done) is suppressed in that cycle.
    assign timed_end = (state == PLAY) && !change &&
                       (tick_cnt == TK_LAST) && (tick_count == d_cur - 4'd1);

    // State an accepted command word leads to; the all-zero word means stop.
    function automatic state_t accept_state(input logic [15:0] cmd);
        if (cmd[15:12] != 4'd0)
            return PLAY;
        else if (cmd[11:0] != 12'd0)
            return SUSTAIN;
        else
            return IDLE;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (change)
                    state_next = accept_state(bus.audio_cmd);
            end
            PLAY: begin
                if (change)
                    state_next = accept_state(bus.audio_cmd);
                else if (timed_end)
                    state_next = IDLE;
            end
            SUSTAIN: begin
                if (change)
                    state_next = accept_state(bus.audio_cmd);
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.note_done = timed_end;
        // mute only gates the output; the tone register keeps its phase
        bus.speaker   = tone & ~bus.mute;
    end

    // ------------------------------------------------------------------
    // Command latch, pitch path and duration path
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_prev   <= 16'd0;
            prescale   <= '0;
            half_cnt   <= 12'd0;
            tick_cnt   <= '0;
            tick_count <= 4'd0;
            tone       <= 1'b0;
        end else if (change) begin
            // Accept (or abort into) the new word: every note starts from phase zero.
            cmd_prev   <= bus.audio_cmd;
            prescale   <= '0;
            half_cnt   <= 12'd0;
            tick_cnt   <= '0;
            tick_count <= 4'd0;
            tone       <= 1'b0;
        end else if ((state == IDLE) || timed_end) begin
            prescale   <= '0;
            half_cnt   <= 12'd0;
            tick_cnt   <= '0;
            tick_count <= 4'd0;
            tone       <= 1'b0;
        end else begin
            // Pitch: one half-period is P prescaler wraps; rests never toggle.
            if (prescale == PS_LAST) begin
                prescale <= '0;
                if (p_cur != 12'd0) begin
                    if (half_cnt == p_cur - 12'd1) begin
                        half_cnt <= 12'd0;
                        tone     <= ~tone;
                    end else begin
                        half_cnt <= half_cnt + 12'd1;
                    end
                end
            end else begin
                prescale <= prescale + PW'(1);
            end

            // Duration only advances for timed notes; timed_end stops it at D-1.
            if (state == PLAY) begin
                if (tick_cnt == TK_LAST) begin
                    tick_cnt   <= '0;
                    tick_count <= tick_count + 4'd1;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_tone_player.sv
// tb/tb_audio_tone_player.sv - scoreboard bench for audio_tone_player

module tb_audio_tone_player;

    localparam int PU = 2;
    localparam int TC = 20;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    audio_tone_if bus();

    audio_tone_player #(
        .PITCH_UNIT (PU),
        .TICK_CYCLES(TC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] v;     // {speaker, busy, note_done}
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input int c, input logic spk, input logic bsy, input logic nd);
        exp_t e;
        e.cyc = c;
        e.v   = {spk, bsy, nd};
        sb.push_back(e);
    endtask

    task automatic push_idle(input int from, input int cnt);
        for (int i = 0; i < cnt; i++)
            push_exp(from + i, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected outputs for cycles n+1..n+cnt after a word accepted at the
    // edge ending cycle n. Speaker is low inside the mute window [mf, mt).
    task automatic push_note(input int n, input int p, input int d, input int cnt,
                             input int mf, input int mt);
        for (int k = 1; k <= cnt; k++) begin
            int   c;
            logic in_note;
            logic spk;
            logic nd;
            c       = n + k;
            in_note = (d == 0) || (k <= d * TC);
            spk     = in_note && (p != 0) && ((((k - 1) / (p * PU)) % 2) != 0);
            if (c >= mf && c < mt)
                spk = 1'b0;
            nd      = (d != 0) && (k == d * TC);
            push_exp(c, spk, in_note, nd);
        end
    endtask

    // Advance to cycle c and settle 1 time unit past its opening edge.
    task automatic goto(input int c);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c);
    endtask

    // Monitor: compares every expectation tagged with the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if ({bus.speaker, bus.busy, bus.note_done} !== sb[i].v) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: spk/busy/done got %b%b%b want %b%b%b",
                             cyc, bus.speaker, bus.busy, bus.note_done,
                             sb[i].v[2], sb[i].v[1], sb[i].v[0]);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int m;

        reset         = 1'b1;
        bus.audio_cmd = 16'h0000;
        bus.mute      = 1'b0;

        // Reset state
        goto(3);
        push_idle(cyc, 1);
        reset = 1'b0;
        push_idle(cyc + 1, 3);
        goto(cyc + 4);

        // Timed note 0x3005, then the held word must not retrigger
        bus.audio_cmd = 16'h3005;
        n = cyc;
        push_note(n, 5, 3, 70, 0, 0);
        goto(n + 70);

        // Sustained 0x0004 with a mute window, then stop with 0x0000
        bus.audio_cmd = 16'h0004;
        n = cyc;
        push_note(n, 4, 0, 60, n + 20, n + 36);
        goto(n + 20);
        bus.mute = 1'b1;
        goto(n + 36);
        bus.mute = 1'b0;
        goto(n + 60);
        bus.audio_cmd = 16'h0000;
        push_idle(n + 61, 5);
        goto(n + 66);

        // Timed rest 0x2000
        bus.audio_cmd = 16'h2000;
        n = cyc;
        push_note(n, 0, 2, 45, 0, 0);
        goto(n + 45);

        // Abort 0x3005 at its 25th cycle with 0x1003
        bus.audio_cmd = 16'h3005;
        n = cyc;
        push_note(n, 5, 3, 25, 0, 0);
        goto(n + 25);
        bus.audio_cmd = 16'h1003;
        m = cyc;
        push_note(m, 3, 1, 25, 0, 0);
        goto(m + 25);

        // Change landing on the natural end of 0x1001: no note_done
        bus.audio_cmd = 16'h1001;
        n = cyc;
        push_note(n, 1, 1, 19, 0, 0);
        goto(n + 20);
        bus.audio_cmd = 16'h1002;
        push_exp(cyc, 1'b1, 1'b1, 1'b0);
        m = cyc;
        push_note(m, 2, 1, 22, 0, 0);
        goto(m + 22);

        // Reset mid-note with 0x3005 held: re-accepted after release
        bus.audio_cmd = 16'h3005;
        n = cyc;
        push_note(n, 5, 3, 15, 0, 0);
        goto(n + 15);
        reset = 1'b1;
        push_idle(n + 16, 2);
        goto(n + 17);
        reset = 1'b0;
        push_note(n + 17, 5, 3, 62, 0, 0);
        goto(n + 17 + 64);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_tone_player.md
# audio_tone_player

Square-wave tone generator that consumes the 16-bit audio command word the CPU stores to the memory-mapped audio address (60000). It continuously samples the held command register, starts a new note whenever the word changes, and drives a 1-bit speaker line, with timed or sustained notes and rests. It sits between the memory block's audio register output and the board audio/GPIO pin.

## Interface
- PITCH_UNIT, 50: clock cycles per pitch unit (1 µs at 50 MHz).
- TICK_CYCLES, 3125000: clock cycles per duration tick (62.5 ms at 50 MHz).
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- audio_cmd  input  16  held command word: [15:12] duration D, [11:0] half-period P.
- mute  input  1  forces speaker low; counters keep running.
- speaker  output  1  square-wave output.
- busy  output  1  high while a note or rest is in progress.
- note_done  output  1  one-cycle pulse when a timed note ends naturally.

## Operation
- Command word meaning: P = half-period in PITCH_UNIT units (P=1136 → ~440 Hz); P=0 is a rest (speaker held 0, timing still runs). D=1..15: note lasts D ticks. D=0: sustained, plays until next command.
- Change detection: register cmd_prev holds the last accepted word; a new command is detected in any cycle where audio_cmd != cmd_prev. audio_cmd=0 (D=0, P=0) is a sustained rest, i.e. stop.
- States: IDLE, PLAY (timed), SUSTAIN (D=0).
  - IDLE → PLAY on change with D≠0; IDLE → SUSTAIN on change with D=0 and P≠0; change to 0 stays IDLE.
  - PLAY → IDLE when duration count reaches D ticks; assert note_done that cycle.
  - PLAY/SUSTAIN → new state on any change (abort): counters cleared, speaker forced 0, no note_done.
- On accept: cmd_prev, D, P latched; prescaler, half-period counter, tick counter, tick count cleared; speaker set 0.
- Pitch path: prescaler counts 0..PITCH_UNIT-1; on wrap, half-period counter increments; when it reaches P, it clears and speaker toggles (only if P≠0).
- Duration path (PLAY only): tick counter counts 0..TICK_CYCLES-1; on wrap, tick count (4-bit) increments; end when tick count reaches D.
- speaker output = toggle register AND NOT mute. mute does not affect busy, note_done or counters.
- busy = state ≠ IDLE.
- Counter widths: prescaler and tick counter sized by $clog2 of their parameter; half-period counter 12 bits; tick count 4 bits; no wrap beyond terminal values.

## Timing
- Reset: state IDLE, cmd_prev=0, all counters 0, speaker=0, busy=0, note_done=0.
- Change on audio_cmd visible in cycle N → accepted at edge ending N; busy high from cycle N+1.
- First speaker edge at cycle N+1+P·PITCH_UNIT; subsequent edges every P·PITCH_UNIT cycles.
- Timed note: busy high for exactly D·TICK_CYCLES cycles; note_done pulses in the last busy cycle; busy low and speaker 0 the cycle after.
- Change coinciding with natural end: change wins, new note starts, no note_done.
- Same word rewritten by CPU: no change seen, no retrigger (firmware must write a different word or 0 in between).
- reset asserted mid-note: next cycle all outputs at reset values; cmd_prev=0, so a nonzero held audio_cmd is re-accepted once reset deasserts.
- mute: speaker follows mute combinationally through the AND, no counter effect.

## Test plan
- PITCH_UNIT=2, TICK_CYCLES=20; after reset write audio_cmd=0x3005 → busy rises next cycle, speaker toggles every 10 cycles, busy high 60 cycles, note_done single pulse on the last, speaker 0 after.
- audio_cmd=0x0004 (sustained) → speaker period 16 cycles indefinitely, no note_done; then audio_cmd=0x0000 → busy low and speaker 0 next cycle.
- audio_cmd=0x2000 (rest, D=2) → speaker stays 0, busy high 40 cycles, note_done pulse.
- Mid-note at cycle 25 of 0x3005 write 0x1003 → counters restart, speaker 0, first toggle 6 cycles later, busy 20 more cycles, exactly one note_done (second note only).
- mute=1 during 0x0004 → speaker 0; mute=0 → speaker resumes in phase with unmuted toggle register.
- reset pulse mid-note with audio_cmd held at 0x3005 → outputs reset next cycle, note restarts from zero after reset release.
